alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Multi-slot alarm controller that sits between the clock's running-time register and the alarm output. It holds NUM_SLOTS programmable BCD alarm times and watches the BCD HHMM time bus for minute changes. When a change matches an alarm, it arbitrates between matching slots and sequences the ring / snooze / dismiss lifecycle. It replaces direct single-compare alarm logic; the buzzer driver consumes `ring`.

## Interface

**Parameters**
- NUM_SLOTS, 4 — number of alarm slots, 1..4.
- SNOOZE_MIN, 5 — snooze length in minutes, 1..59.
- RING_SECS, 60 — ring timeout in sec_tick pulses, ≥1.
- MAX_SNOOZE, 3 — snoozes allowed per alarm event, 1..3.

**Ports**
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_time  in  16  current time, BCD HHMM ([15:12] tens-hr, [11:8] hr, [7:4] tens-min, [3:0] min).
- sec_tick  in  1  one-cycle pulse once per second.
- wr_en  in  1  slot write strobe.
- wr_slot  in  2  slot index for the write.
- wr_time  in  16  BCD HHMM value to program.
- wr_enable  in  1  enable bit for the written slot.
- snooze  in  1  one-cycle snooze request.
- dismiss  in  1  one-cycle dismiss request.
- ring  out  1  alarm sounding.
- active_slot  out  2  slot owning the current event.
- snooze_count  out  2  snoozes used in the current event.
- wr_err  out  1  one-cycle pulse: write rejected.
- missed  out  1  one-cycle pulse: an enabled match was dropped.

## Operation

**Reset state**
- state IDLE.
- All outputs 0.
- All slots time 16'h0000, disabled.
- prev_time 16'h0000; snooze_time 16'h0000; second counter 0.

**Minute edge**
- `min_edge = (in_time != prev_time)`.
- prev_time is updated every cycle.

**Slot writes**
- Accepted in any state.
- A write is rejected (slot unchanged, wr_err=1 next cycle) if any of these hold:
  - wr_slot ≥ NUM_SLOTS;
  - hours > 23;
  - minutes > 59;
  - any nibble > 9.

**IDLE**
- On min_edge, every enabled slot whose time equals in_time matches.
- Lowest matching index wins → RING:
  - active_slot = that index;
  - snooze_count = 0;
  - second counter cleared.
- Each additional matching slot beyond the winner causes missed=1 for one cycle.

**RING** (ring=1)
- dismiss → IDLE.
- snooze with snooze_count < MAX_SNOOZE → SNOOZE:
  - snooze_time = in_time + SNOOZE_MIN in BCD;
  - snooze_count increments.
- snooze with snooze_count == MAX_SNOOZE → IDLE (treated as dismiss).
- The second counter increments on each sec_tick. When it reaches RING_SECS → IDLE.
- Any enabled slot match on min_edge → missed pulse; no state change.

**SNOOZE** (ring=0)
- On min_edge with in_time == snooze_time → RING; second counter cleared.
- dismiss → IDLE.
- Other slot matches → missed pulse.

**Common rules**
- A write to active_slot with wr_enable=0 while in RING or SNOOZE → IDLE (event cancelled).
- snooze and dismiss in the same cycle: dismiss wins.
- BCD add: minutes ≥ 60 subtract 60 and carry 1 into the hour; hour 24 wraps to 00. Examples: 2358 + 5 = 0003; 0957 + 5 = 1002.
- active_slot and snooze_count hold their last values in IDLE until the next event.

## Timing
- All outputs are registered.
- in_time changes to a matching value in cycle N → ring=1 from cycle N+1.
- snooze or dismiss sampled in cycle N → ring=0 from cycle N+1.
- The RING_SECS-th sec_tick in RING at cycle N → ring=0 from N+1.
- A write in cycle N takes effect for comparisons in N+1. A write and a min_edge in the same cycle compare against the old slot contents.
- wr_err and missed are exactly one cycle wide.
- rst low mid-event → ring=0 immediately (asynchronous); all slots are cleared.

## Test plan
1. **Basic match and dismiss.** Write slot0=16'h1209 enabled. Step in_time 1200→1209 one minute per 10 cycles. Expect ring=1 the cycle after 1209 and active_slot=0. Pulse dismiss; expect ring=0 next cycle.
2. **Snooze with wrap, then limit.** Slot1=16'h2358, in_time reaches 2358, ring; pulse snooze. Expect ring=0, snooze_count=1. Step in_time to 0003; expect ring=1. Snooze to MAX_SNOOZE (3); a 4th snooze → IDLE, ring=0.
3. **Arbitration.** Slots 0, 2 and 3 all =16'h0730 enabled; in_time → 0730. Expect active_slot=0 and two missed pulses. Disabled slot matches produce no pulse.
4. **Timeout.** RING_SECS=60. In RING, issue 59 sec_ticks: ring stays 1. Issue the 60th: ring=0 next cycle.
5. **Invalid write.** wr_time=16'h2460 or 16'h1A00 → wr_err pulse, slot unchanged. Cancel case: in SNOOZE, write active_slot with wr_enable=0 → IDLE; the snooze time passes with no ring.
6. **Priority and reset.** snooze+dismiss together → IDLE, snooze_count unchanged. Assert rst low during RING → ring=0 asynchronously. After release, the old alarm time produces no ring.

Source files
------------

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: multi-slot BCD alarm controller.
// Holds NUM_SLOTS programmable HHMM alarm times, watches the running-time bus
// for minute changes, arbitrates between matching slots and sequences the
// ring / snooze / dismiss lifecycle for the buzzer driver.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   in_time      current time, BCD HHMM
//   sec_tick     one-cycle pulse per second
//   wr_en        slot write strobe (wr_slot, wr_time, wr_enable qualify it)
//   snooze       one-cycle snooze request
//   dismiss      one-cycle dismiss request (beats snooze)
//   ring         alarm sounding
//   active_slot  slot owning the current event
//   snooze_count snoozes used in the current event
//   wr_err       one-cycle pulse: write rejected
//   missed       one-cycle pulse per dropped enabled match
//
// state  | meaning
// IDLE   | no event; waiting for a minute edge that matches an enabled slot
// RING   | ring asserted; counting sec_tick toward the ring timeout
// SNOOZE | ring silenced; waiting for in_time to reach snooze_time
module alarm_ctrl #(
  parameter int NUM_SLOTS  = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_time,
  input  logic        sec_tick,
  input  logic        wr_en,
  input  logic [1:0]  wr_slot,
  input  logic [15:0] wr_time,
  input  logic        wr_enable,
  input  logic        snooze,
  input  logic        dismiss,
  output logic        ring,
  output logic [1:0]  active_slot,
  output logic [1:0]  snooze_count,
  output logic        wr_err,
  output logic        missed
);

  localparam int SEC_W = $clog2(RING_SECS + 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t state, state_next;

  logic [15:0]          slot_time [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_en;
  logic [15:0]          prev_time;
  logic [15:0]          snooze_time, snooze_time_next;
  logic [SEC_W-1:0]     sec_cnt, sec_cnt_next;
  logic [1:0]           slot_next, count_next;
  logic [3:0]           miss_pending, miss_pending_next;
  logic                 missed_next;

  logic [NUM_SLOTS-1:0] match;
  logic [2:0]           match_cnt;
  logic                 win_found;
  logic [1:0]           win_idx;
  logic [2:0]           extra;
  logic [4:0]           miss_total;
  logic                 min_edge, wr_ok, cancel, timeout;

  function automatic logic bcd_valid(input logic [15:0] t);
    logic ok;
    ok = (t[15:12] <= 4'd2) && (t[11:8] <= 4'd9) &&
         (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    if (t[15:12] == 4'd2 && t[11:8] > 4'd3) ok = 1'b0;
    return ok;
  endfunction

  // HHMM + SNOOZE_MIN, done in binary then converted back to BCD.
  function automatic logic [15:0] bcd_add_snooze(input logic [15:0] t);
    logic [7:0] mins, hrs;
    mins = 8'(t[7:4]) * 8'd10 + 8'(t[3:0]) + 8'(SNOOZE_MIN);
    hrs  = 8'(t[15:12]) * 8'd10 + 8'(t[11:8]);
    if (mins >= 8'd60) begin
      mins = mins - 8'd60;
      hrs  = hrs + 8'd1;
    end
    if (hrs >= 8'd24) hrs = hrs - 8'd24;
    return {4'(hrs / 8'd10), 4'(hrs % 8'd10), 4'(mins / 8'd10), 4'(mins % 8'd10)};
  endfunction

  assign min_edge = (in_time != prev_time);
  assign wr_ok    = wr_en && ({1'b0, wr_slot} < 3'(NUM_SLOTS)) && bcd_valid(wr_time);
  assign cancel   = wr_ok && !wr_enable && (wr_slot == active_slot) && (state != IDLE);
  assign timeout  = sec_tick && (sec_cnt == SEC_W'(RING_SECS - 1));

  // Slot compare uses the registered slot contents, so a write in the same
  // cycle as a minute edge only affects the following cycles.
  always_comb begin
    match     = '0;
    match_cnt = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      match[i] = slot_en[i] && (slot_time[i] == in_time);
      if (match[i]) begin
        match_cnt = match_cnt + 3'd1;
        if (!win_found) begin
          win_found = 1'b1;
          win_idx   = 2'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next       = state;
    slot_next        = active_slot;
    count_next       = snooze_count;
    sec_cnt_next     = sec_cnt;
    snooze_time_next = snooze_time;
    extra            = '0;
    case (state)
      IDLE: begin
        if (min_edge && win_found) begin
          state_next   = RING;
          slot_next    = win_idx;
          count_next   = '0;
          sec_cnt_next = '0;
          extra        = match_cnt - 3'd1;
        end
      end
      RING: begin
        if (min_edge) extra = match_cnt;
        if (sec_tick) sec_cnt_next = sec_cnt + SEC_W'(1);
        if (dismiss || cancel) begin
          state_next = IDLE;
        end else if (snooze) begin
          if (snooze_count < 2'(MAX_SNOOZE)) begin
            state_next       = SNOOZE;
            snooze_time_next = bcd_add_snooze(in_time);
            count_next       = snooze_count + 2'd1;
          end else begin
            state_next = IDLE;
          end
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      SNOOZE: begin
        if (min_edge) extra = match_cnt;
        if (dismiss || cancel) begin
          state_next = IDLE;
        end else if (min_edge && in_time == snooze_time) begin
          state_next   = RING;
          sec_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    // Several misses can arrive on one edge; they are queued and emitted as
    // separate one-cycle pulses with a low cycle between them.
    miss_total  = 5'(miss_pending) + 5'(extra);
    missed_next = !missed && (miss_total != 5'd0);
    miss_total  = miss_total - 5'(missed_next);
    miss_pending_next = (miss_total > 5'd15) ? 4'd15 : miss_total[3:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_time[i] <= '0;
      slot_en      <= '0;
      prev_time    <= '0;
      snooze_time  <= '0;
      sec_cnt      <= '0;
      miss_pending <= '0;
      ring         <= 1'b0;
      active_slot  <= '0;
      snooze_count <= '0;
      wr_err       <= 1'b0;
      missed       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_ok && wr_slot == 2'(i)) begin
          slot_time[i] <= wr_time;
          slot_en[i]   <= wr_enable;
        end
      end
      prev_time    <= in_time;
      snooze_time  <= snooze_time_next;
      sec_cnt      <= sec_cnt_next;
      miss_pending <= miss_pending_next;
      ring         <= (state_next == RING);
      active_slot  <= slot_next;
      snooze_count <= count_next;
      wr_err       <= wr_en && !wr_ok;
      missed       <= missed_next;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with default parameters
// (4 slots, 5 minute snooze, 60 second ring timeout, 3 snoozes).
module tb_alarm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_time;
  logic        sec_tick, wr_en, wr_enable, snooze, dismiss;
  logic [1:0]  wr_slot;
  logic [15:0] wr_time;
  logic        ring, wr_err, missed;
  logic [1:0]  active_slot, snooze_count;

  int checks = 0;
  int errors = 0;
  int miss_cnt = 0;
  logic missed_prev = 1'b0;

  alarm_ctrl dut (
    .clk(clk), .rst(rst), .in_time(in_time), .sec_tick(sec_tick),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_time(wr_time), .wr_enable(wr_enable),
    .snooze(snooze), .dismiss(dismiss), .ring(ring), .active_slot(active_slot),
    .snooze_count(snooze_count), .wr_err(wr_err), .missed(missed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] alarm;
    logic [15:0] near;
    logic [15:0] wake;
  } snz_vec_t;

  typedef struct {
    logic [1:0]  slot;
    logic [15:0] t;
    logic        en;
    logic        exp_err;
  } wr_vec_t;

  snz_vec_t snz_tab [5];
  wr_vec_t  wr_tab  [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Missed must come as isolated one-cycle pulses.
  always @(negedge clk) begin
    if (missed) begin
      miss_cnt++;
      check("missed_width", {31'd0, missed_prev}, 32'd0);
    end
    missed_prev = missed;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [15:0] t);
    in_time = t;
    tick();
  endtask

  task automatic wr(input logic [1:0] s, input logic [15:0] t, input logic en);
    wr_en = 1'b1; wr_slot = s; wr_time = t; wr_enable = en;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_snooze();
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
  endtask

  task automatic do_dismiss();
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
  endtask

  logic [15:0] wake_seq [3];

  initial begin
    snz_tab[0] = '{16'h2358, 16'h0002, 16'h0003};
    snz_tab[1] = '{16'h0957, 16'h1001, 16'h1002};
    snz_tab[2] = '{16'h1230, 16'h1234, 16'h1235};
    snz_tab[3] = '{16'h1959, 16'h2003, 16'h2004};
    snz_tab[4] = '{16'h2355, 16'h2359, 16'h0000};

    wr_tab[0] = '{2'd3, 16'h2460, 1'b1, 1'b1};
    wr_tab[1] = '{2'd3, 16'h1A00, 1'b1, 1'b1};
    wr_tab[2] = '{2'd3, 16'h2400, 1'b1, 1'b1};
    wr_tab[3] = '{2'd3, 16'h1560, 1'b1, 1'b1};
    wr_tab[4] = '{2'd3, 16'h150A, 1'b1, 1'b1};
    wr_tab[5] = '{2'd3, 16'h3000, 1'b1, 1'b1};
    wr_tab[6] = '{2'd2, 16'h2359, 1'b0, 1'b0};
    wr_tab[7] = '{2'd2, 16'h0000, 1'b0, 1'b0};

    wake_seq[0] = 16'h0003;
    wake_seq[1] = 16'h0008;
    wake_seq[2] = 16'h0013;

    rst = 1'b0; in_time = 16'h0000; sec_tick = 1'b0; wr_en = 1'b0;
    wr_slot = 2'd0; wr_time = 16'h0000; wr_enable = 1'b0;
    snooze = 1'b0; dismiss = 1'b0;
    repeat (3) tick();
    check("reset_ring", {31'd0, ring}, 32'd0);
    check("reset_active", {30'd0, active_slot}, 32'd0);
    check("reset_count", {30'd0, snooze_count}, 32'd0);
    check("reset_wr_err", {31'd0, wr_err}, 32'd0);
    check("reset_missed", {31'd0, missed}, 32'd0);
    rst = 1'b1;
    tick();

    // Basic match and dismiss
    wr(2'd0, 16'h1209, 1'b1);
    check("t1_wr_err", {31'd0, wr_err}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      in_time = 16'h1200 + 16'(i);
      repeat (10) tick();
    end
    check("t1_no_ring_early", {31'd0, ring}, 32'd0);
    set_time(16'h1209);
    check("t1_ring", {31'd0, ring}, 32'd1);
    check("t1_active", {30'd0, active_slot}, 32'd0);
    repeat (5) tick();
    check("t1_ring_hold", {31'd0, ring}, 32'd1);
    do_dismiss();
    check("t1_dismiss", {31'd0, ring}, 32'd0);

    // Snooze arithmetic across minute/hour/day carries
    for (int i = 0; i < 5; i++) begin
      wr(2'd1, snz_tab[i].alarm, 1'b1);
      set_time(snz_tab[i].alarm);
      check("snz_ring", {31'd0, ring}, 32'd1);
      check("snz_active", {30'd0, active_slot}, 32'd1);
      do_snooze();
      check("snz_quiet", {31'd0, ring}, 32'd0);
      check("snz_count", {30'd0, snooze_count}, 32'd1);
      set_time(snz_tab[i].near);
      check("snz_near", {31'd0, ring}, 32'd0);
      set_time(snz_tab[i].wake);
      check("snz_wake", {31'd0, ring}, 32'd1);
      do_dismiss();
      check("snz_dismiss", {31'd0, ring}, 32'd0);
    end

    // Snooze limit
    wr(2'd1, 16'h2358, 1'b1);
    set_time(16'h2358);
    check("lim_ring", {31'd0, ring}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      do_snooze();
      check("lim_quiet", {31'd0, ring}, 32'd0);
      check("lim_count", {30'd0, snooze_count}, 32'(k + 1));
      set_time(wake_seq[k]);
      check("lim_wake", {31'd0, ring}, 32'd1);
    end
    do_snooze();
    check("lim_final_quiet", {31'd0, ring}, 32'd0);
    check("lim_final_count", {30'd0, snooze_count}, 32'd3);
    set_time(16'h0018);
    check("lim_idle", {31'd0, ring}, 32'd0);

    // Arbitration
    wr(2'd1, 16'h0730, 1'b0);
    wr(2'd0, 16'h0730, 1'b1);
    wr(2'd2, 16'h0730, 1'b1);
    wr(2'd3, 16'h0730, 1'b1);
    miss_cnt = 0;
    set_time(16'h0730);
    check("arb_ring", {31'd0, ring}, 32'd1);
    check("arb_active", {30'd0, active_slot}, 32'd0);
    repeat (8) tick();
    check("arb_missed", miss_cnt, 32'd2);
    wr(2'd2, 16'h0731, 1'b1);
    set_time(16'h0731);
    repeat (4) tick();
    check("arb_ring_missed", miss_cnt, 32'd3);
    check("arb_ring_hold", {31'd0, ring}, 32'd1);
    check("arb_active_hold", {30'd0, active_slot}, 32'd0);
    do_dismiss();
    check("arb_dismiss", {31'd0, ring}, 32'd0);
    wr(2'd2, 16'h0000, 1'b0);
    wr(2'd3, 16'h0000, 1'b0);

    // Ring timeout
    wr(2'd0, 16'h0800, 1'b1);
    set_time(16'h0800);
    check("to_ring", {31'd0, ring}, 32'd1);
    for (int i = 0; i < 59; i++) begin
      sec_tick = 1'b1;
      tick();
      sec_tick = 1'b0;
      tick();
    end
    check("to_59", {31'd0, ring}, 32'd1);
    sec_tick = 1'b1;
    tick();
    sec_tick = 1'b0;
    check("to_60", {31'd0, ring}, 32'd0);

    // Write validation
    wr(2'd3, 16'h1500, 1'b1);
    check("wr_valid", {31'd0, wr_err}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      wr(wr_tab[i].slot, wr_tab[i].t, wr_tab[i].en);
      check("wr_err", {31'd0, wr_err}, {31'd0, wr_tab[i].exp_err});
      tick();
      check("wr_err_width", {31'd0, wr_err}, 32'd0);
    end
    set_time(16'h1500);
    check("wr_slot_kept", {31'd0, ring}, 32'd1);
    check("wr_slot_active", {30'd0, active_slot}, 32'd3);
    do_dismiss();

    // Cancel during SNOOZE
    set_time(16'h1501);
    set_time(16'h1500);
    check("cn_ring", {31'd0, ring}, 32'd1);
    do_snooze();
    wr(2'd3, 16'h1500, 1'b0);
    set_time(16'h1504);
    set_time(16'h1505);
    check("cn_snooze_cancelled", {31'd0, ring}, 32'd0);

    // Cancel during RING
    set_time(16'h0800);
    check("cr_ring", {31'd0, ring}, 32'd1);
    check("cr_active", {30'd0, active_slot}, 32'd0);
    wr(2'd0, 16'h0800, 1'b0);
    check("cr_cancel", {31'd0, ring}, 32'd0);

    // Snooze and dismiss together
    wr(2'd1, 16'h1000, 1'b1);
    set_time(16'h1000);
    do_snooze();
    check("pr_count1", {30'd0, snooze_count}, 32'd1);
    set_time(16'h1005);
    check("pr_ring", {31'd0, ring}, 32'd1);
    snooze = 1'b1; dismiss = 1'b1;
    tick();
    snooze = 1'b0; dismiss = 1'b0;
    check("pr_quiet", {31'd0, ring}, 32'd0);
    check("pr_count", {30'd0, snooze_count}, 32'd1);
    set_time(16'h1010);
    check("pr_idle", {31'd0, ring}, 32'd0);

    // Asynchronous reset mid-ring
    set_time(16'h0959);
    set_time(16'h1000);
    check("rs_ring", {31'd0, ring}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rs_async", {31'd0, ring}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    check("rs_active", {30'd0, active_slot}, 32'd0);
    check("rs_count", {30'd0, snooze_count}, 32'd0);
    set_time(16'h0959);
    set_time(16'h1000);
    check("rs_slots_cleared", {31'd0, ring}, 32'd0);
    repeat (2) tick();
    check("rs_still_quiet", {31'd0, ring}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
